fp_mul_pipe: RTL and testbench

Pipelined IEEE-754 single-precision multiplier: the design-under-test that sits behind the multiplier bench interface. It accepts operands `fp_X` and `fp_Y` plus a rounding mode `r_mode`, and returns `fp_Z` with overflow/underflow flags.
- Three-stage pipeline, one operation accepted per cycle, no backpressure.
- Subnormals are flushed to zero.

---
 rtl/fp_mul_pipe.sv | 207 ++++++++++++++++++++
 tb/tb_fp_mul_pipe.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_mul_pipe.sv
// fp_mul_pipe: pipelined binary32 multiplier with flush-to-zero.
// Operands are captured at the input boundary, then unpacked/classified,
// multiplied, and finally normalized/rounded/packed into the output registers.
// Optional sticky overflow/underflow flags: define FP_MUL_STICKY_FLAGS_EN.
module fp_mul_pipe (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [2:0]  r_mode,
    input  logic [31:0] fp_X,
    input  logic [31:0] fp_Y,
`ifdef FP_MUL_STICKY_FLAGS_EN
    input  logic        flag_clr,
    output logic        ovrf_sticky,
    output logic        udrf_sticky,
`endif
    output logic        out_valid,
    output logic [31:0] fp_Z,
    output logic        ovrf,
    output logic        udrf
);
    localparam logic [2:0] MODE_RTZ = 3'b001;
    localparam logic [2:0] MODE_RDN = 3'b010;
    localparam logic [2:0] MODE_RUP = 3'b011;
    localparam logic [2:0] MODE_RMM = 3'b100;

    // Input boundary registers
    logic        in_valid_q;
    logic [31:0] x_q, y_q;
    logic [2:0]  mode_q;

    // S1: unpacked operands and their classes (index 0 = X, 1 = Y)
    logic        s1_valid_q, s1_sx_q, s1_sy_q;
    logic [7:0]  s1_ex_q, s1_ey_q;
    logic [23:0] s1_mx_q, s1_my_q;
    logic [1:0]  s1_zero_q, s1_inf_q, s1_nan_q;
    logic [2:0]  s1_mode_q;

    // S2: raw product, provisional exponent, resolved special cases
    logic               s2_valid_q, s2_sign_q;
    logic signed [9:0]  s2_exp_q;
    logic [47:0]        s2_prod_q;
    logic               s2_nan_q, s2_inf_q, s2_zero_q;
    logic [2:0]         s2_mode_q;

    // S3: output registers
    logic        out_valid_q, ovrf_q, udrf_q;
    logic [31:0] fp_z_q;

    // Operand classification, identical for both operands
    logic [1:0][31:0] op_w;
    logic [1:0]       zero_d, inf_d, nan_d;
    assign op_w = {y_q, x_q};
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_cls
            assign zero_d[gi] = (op_w[gi][30:23] == 8'h00);
            assign inf_d[gi]  = (op_w[gi][30:23] == 8'hFF) && (op_w[gi][22:0] == 23'd0);
            assign nan_d[gi]  = (op_w[gi][30:23] == 8'hFF) && (op_w[gi][22:0] != 23'd0);
        end
    endgenerate

    // S2 next-state: significand product, exponent sum and special-case priority
    logic [47:0]       s2_prod_d;
    logic signed [9:0] s2_exp_d;
    logic              s2_nan_d;
    assign s2_prod_d = {24'd0, s1_mx_q} * {24'd0, s1_my_q};
    assign s2_exp_d  = $signed({2'b00, s1_ex_q}) + $signed({2'b00, s1_ey_q}) - 10'sd127;
    assign s2_nan_d  = (|s1_nan_q) | (s1_inf_q[0] & s1_zero_q[1]) | (s1_inf_q[1] & s1_zero_q[0]);

    // S3 next-state: normalize, round, detect range errors, pack
    logic              hi, grd, rnd, stk, inc, to_inf;
    logic [23:0]       m_norm;
    logic [24:0]       m_rnd;
    logic [22:0]       frac;
    logic signed [9:0] e_norm, e_rnd;
    logic [31:0]       z_d;
    logic              ov_d, ud_d;

    // Rounding and result selection for the operation in S2
    always_comb begin
        hi     = s2_prod_q[47];
        m_norm = hi ? s2_prod_q[47:24] : s2_prod_q[46:23];
        grd    = hi ? s2_prod_q[23] : s2_prod_q[22];
        rnd    = hi ? s2_prod_q[22] : s2_prod_q[21];
        stk    = hi ? (|s2_prod_q[21:0]) : (|s2_prod_q[20:0]);
        e_norm = s2_exp_q + $signed({9'd0, hi});
        case (s2_mode_q)
            MODE_RTZ: begin inc = 1'b0;                           to_inf = 1'b0;        end
            MODE_RDN: begin inc = s2_sign_q & (grd | rnd | stk);  to_inf = s2_sign_q;   end
            MODE_RUP: begin inc = ~s2_sign_q & (grd | rnd | stk); to_inf = ~s2_sign_q;  end
            MODE_RMM: begin inc = grd;                            to_inf = 1'b1;        end
            default:  begin inc = grd & (rnd | stk | m_norm[0]);  to_inf = 1'b1;        end
        endcase
        m_rnd = {1'b0, m_norm} + {24'd0, inc};
        // A carry out of the significand leaves 1.000..., so the fraction is zero
        e_rnd = e_norm + $signed({9'd0, m_rnd[24]});
        frac  = m_rnd[24] ? m_rnd[23:1] : m_rnd[22:0];
        z_d   = {s2_sign_q, e_rnd[7:0], frac};
        ov_d  = 1'b0;
        ud_d  = 1'b0;
        if (s2_nan_q) begin
            z_d = 32'h7FC00000;
        end else if (s2_inf_q) begin
            z_d = {s2_sign_q, 8'hFF, 23'd0};
        end else if (s2_zero_q) begin
            z_d = {s2_sign_q, 31'd0};
        end else if (e_rnd >= 10'sd255) begin
            ov_d = 1'b1;
            z_d  = to_inf ? {s2_sign_q, 8'hFF, 23'd0} : {s2_sign_q, 31'h7F7FFFFF};
        end else if (e_rnd <= 10'sd0) begin
            ud_d = 1'b1;
            z_d  = {s2_sign_q, 31'd0};
        end
    end

    // Pipeline registers; outputs only update when a valid result arrives
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_valid_q  <= 1'b0;
            x_q         <= '0;
            y_q         <= '0;
            mode_q      <= '0;
            s1_valid_q  <= 1'b0;
            s1_sx_q     <= 1'b0;
            s1_sy_q     <= 1'b0;
            s1_ex_q     <= '0;
            s1_ey_q     <= '0;
            s1_mx_q     <= '0;
            s1_my_q     <= '0;
            s1_zero_q   <= '0;
            s1_inf_q    <= '0;
            s1_nan_q    <= '0;
            s1_mode_q   <= '0;
            s2_valid_q  <= 1'b0;
            s2_sign_q   <= 1'b0;
            s2_exp_q    <= '0;
            s2_prod_q   <= '0;
            s2_nan_q    <= 1'b0;
            s2_inf_q    <= 1'b0;
            s2_zero_q   <= 1'b0;
            s2_mode_q   <= '0;
            out_valid_q <= 1'b0;
            fp_z_q      <= '0;
            ovrf_q      <= 1'b0;
            udrf_q      <= 1'b0;
        end else begin
            in_valid_q  <= in_valid;
            x_q         <= fp_X;
            y_q         <= fp_Y;
            mode_q      <= r_mode;
            s1_valid_q  <= in_valid_q;
            s1_sx_q     <= x_q[31];
            s1_sy_q     <= y_q[31];
            s1_ex_q     <= x_q[30:23];
            s1_ey_q     <= y_q[30:23];
            s1_mx_q     <= {1'b1, x_q[22:0]};
            s1_my_q     <= {1'b1, y_q[22:0]};
            s1_zero_q   <= zero_d;
            s1_inf_q    <= inf_d;
            s1_nan_q    <= nan_d;
            s1_mode_q   <= mode_q;
            s2_valid_q  <= s1_valid_q;
            s2_sign_q   <= s1_sx_q ^ s1_sy_q;
            s2_exp_q    <= s2_exp_d;
            s2_prod_q   <= s2_prod_d;
            s2_nan_q    <= s2_nan_d;
            s2_inf_q    <= |s1_inf_q;
            s2_zero_q   <= |s1_zero_q;
            s2_mode_q   <= s1_mode_q;
            out_valid_q <= s2_valid_q;
            if (s2_valid_q) begin
                fp_z_q <= z_d;
                ovrf_q <= ov_d;
                udrf_q <= ud_d;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign fp_Z      = fp_z_q;
    assign ovrf      = ovrf_q;
    assign udrf      = udrf_q;

`ifdef FP_MUL_STICKY_FLAGS_EN
    logic ovrf_sticky_q, udrf_sticky_q;

    // Sticky flags: a new flagged result outranks a simultaneous clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovrf_sticky_q <= 1'b0;
            udrf_sticky_q <= 1'b0;
        end else begin
            if (s2_valid_q && ov_d)
                ovrf_sticky_q <= 1'b1;
            else if (flag_clr)
                ovrf_sticky_q <= 1'b0;
            if (s2_valid_q && ud_d)
                udrf_sticky_q <= 1'b1;
            else if (flag_clr)
                udrf_sticky_q <= 1'b0;
        end
    end

    assign ovrf_sticky = ovrf_sticky_q;
    assign udrf_sticky = udrf_sticky_q;
`endif
endmodule

// File: tb/tb_fp_mul_pipe.sv
// Bench for fp_mul_pipe: directed cases with known answers, a mid-flight
// reset, then random traffic checked against an arithmetic reference model.
module tb_fp_mul_pipe;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        flag_clr = 1'b0;
    logic [2:0]  r_mode = 3'd0;
    logic [31:0] fp_X = 32'd0;
    logic [31:0] fp_Y = 32'd0;
    logic        out_valid, ovrf, udrf;
    logic [31:0] fp_Z;
`ifdef FP_MUL_STICKY_FLAGS_EN
    logic        ovrf_sticky, udrf_sticky;
`endif

    always #5 clk = ~clk;

    fp_mul_pipe dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .r_mode     (r_mode),
        .fp_X       (fp_X),
        .fp_Y       (fp_Y),
`ifdef FP_MUL_STICKY_FLAGS_EN
        .flag_clr   (flag_clr),
        .ovrf_sticky(ovrf_sticky),
        .udrf_sticky(udrf_sticky),
`endif
        .out_valid  (out_valid),
        .fp_Z       (fp_Z),
        .ovrf       (ovrf),
        .udrf       (udrf)
    );

    typedef struct {
        int          due;
        logic [31:0] z;
        logic        ov;
        logic        ud;
    } exp_t;

    exp_t        sb[$];
    int          cyc = 0;
    int          n_vec = 0;
    int          n_cmp = 0;
    int          n_fail = 0;
    logic [31:0] last_z = 32'd0;
    logic        last_ov = 1'b0, last_ud = 1'b0;
    logic        stk_o = 1'b0, stk_u = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %08h expected %08h (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    // Reference: exact significand product, rounded by comparing the dropped
    // remainder against one half ulp.
    function automatic void ref_mul(input logic [31:0] x, input logic [31:0] y,
                                    input logic [2:0] md, output logic [31:0] z,
                                    output logic ov, output logic ud);
        int     ex, ey, e, sh;
        bit     sz, xz, yz, xi, yi, xn, yn, up, neg_big;
        longint p, q, rem, half;
        ex = int'(x[30:23]);
        ey = int'(y[30:23]);
        sz = x[31] ^ y[31];
        xz = (ex == 0);
        yz = (ey == 0);
        xi = (ex == 255) && (x[22:0] == 23'd0);
        yi = (ey == 255) && (y[22:0] == 23'd0);
        xn = (ex == 255) && (x[22:0] != 23'd0);
        yn = (ey == 255) && (y[22:0] != 23'd0);
        ov = 1'b0;
        ud = 1'b0;
        z  = 32'd0;
        if (xn || yn || (xi && yz) || (yi && xz)) begin
            z = 32'h7FC00000;
        end else if (xi || yi) begin
            z = {sz, 8'hFF, 23'd0};
        end else if (xz || yz) begin
            z = {sz, 31'd0};
        end else begin
            p    = longint'({1'b1, x[22:0]}) * longint'({1'b1, y[22:0]});
            sh   = (p >= (longint'(1) << 47)) ? 24 : 23;
            e    = ex + ey - 127 + (sh - 23);
            q    = p >> sh;
            rem  = p - (q << sh);
            half = longint'(1) << (sh - 1);
            case (md)
                3'd1:    up = 1'b0;
                3'd2:    up = sz && (rem != 0);
                3'd3:    up = !sz && (rem != 0);
                3'd4:    up = (rem >= half);
                default: up = (rem > half) || ((rem == half) && q[0]);
            endcase
            if (up) q = q + 1;
            if (q == (longint'(1) << 24)) begin
                q = longint'(1) << 23;
                e = e + 1;
            end
            if (e >= 255) begin
                ov = 1'b1;
                // Magnitude goes to infinity unless the mode rounds toward zero for this sign
                neg_big = (md == 3'd1) || (md == 3'd2 && !sz) || (md == 3'd3 && sz);
                z = neg_big ? {sz, 31'h7F7FFFFF} : {sz, 8'hFF, 23'd0};
            end else if (e <= 0) begin
                ud = 1'b1;
                z  = {sz, 31'd0};
            end else begin
                z = {sz, e[7:0], q[22:0]};
            end
        end
    endfunction

    // One clock cycle: drive inputs, advance an edge, check all outputs
    task automatic tick(input logic v, input logic [31:0] x, input logic [31:0] y,
                        input logic [2:0] md, input logic clr, input bit use_ref,
                        input logic [31:0] ez, input logic eov, input logic eud);
        exp_t ent;
        bit   hit;
        in_valid = v;
        fp_X     = x;
        fp_Y     = y;
        r_mode   = md;
        flag_clr = clr;
        ent.z  = ez;
        ent.ov = eov;
        ent.ud = eud;
        if (use_ref) ref_mul(x, y, md, ent.z, ent.ov, ent.ud);
        @(posedge clk);
        cyc++;
        if (v) begin
            ent.due = cyc + 3;
            sb.push_back(ent);
            n_vec++;
        end
        #1;
        hit = (sb.size() > 0) && (sb[0].due == cyc);
        chk("out_valid", out_valid, hit);
        if (hit) begin
            ent     = sb.pop_front();
            last_z  = ent.z;
            last_ov = ent.ov;
            last_ud = ent.ud;
            $display("cycle %0d result fp_Z=%08h ovrf=%b udrf=%b", cyc, fp_Z, ovrf, udrf);
        end
        chk("fp_Z", fp_Z, last_z);
        chk("ovrf", ovrf, last_ov);
        chk("udrf", udrf, last_ud);
`ifdef FP_MUL_STICKY_FLAGS_EN
        if (clr) begin
            stk_o = 1'b0;
            stk_u = 1'b0;
        end
        if (hit && last_ov) stk_o = 1'b1;
        if (hit && last_ud) stk_u = 1'b1;
        chk("ovrf_sticky", ovrf_sticky, stk_o);
        chk("udrf_sticky", udrf_sticky, stk_u);
`endif
    endtask

    task automatic dop(input logic [31:0] x, input logic [31:0] y, input logic [2:0] md,
                       input logic [31:0] ez, input logic eov, input logic eud);
        tick(1'b1, x, y, md, 1'b0, 1'b0, ez, eov, eud);
    endtask

    task automatic rop(input logic [31:0] x, input logic [31:0] y, input logic [2:0] md,
                       input logic clr);
        tick(1'b1, x, y, md, clr, 1'b1, 32'd0, 1'b0, 1'b0);
    endtask

    task automatic idle(input int n, input logic clr);
        for (int i = 0; i < n; i++) tick(1'b0, 32'd0, 32'd0, 3'd0, clr, 1'b0, 32'd0, 1'b0, 1'b0);
    endtask

    // Asynchronous reset: outputs must clear without waiting for a clock edge
    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        #1;
        chk("rst out_valid", out_valid, 1'b0);
        chk("rst fp_Z", fp_Z, 32'd0);
        chk("rst ovrf", ovrf, 1'b0);
        chk("rst udrf", udrf, 1'b0);
        sb.delete();
        last_z  = 32'd0;
        last_ov = 1'b0;
        last_ud = 1'b0;
        stk_o   = 1'b0;
        stk_u   = 1'b0;
`ifdef FP_MUL_STICKY_FLAGS_EN
        chk("rst ovrf_sticky", ovrf_sticky, 1'b0);
        chk("rst udrf_sticky", udrf_sticky, 1'b0);
`endif
        repeat (2) begin
            @(posedge clk);
            cyc++;
        end
        #2;
        rst = 1'b0;
    endtask

    function automatic logic [31:0] rnd_op();
        logic [31:0] v;
        int          k;
        v = $urandom;
        k = $urandom_range(0, 19);
        case (k)
            0: v[30:23] = 8'h00;
            1: begin v[30:23] = 8'hFF; v[22:0] = 23'd0; end
            2: v[30:23] = 8'hFF;
            3: v[30:23] = 8'(126 + $urandom_range(0, 2));
            4: v[30:23] = 8'hFE;
            5: v[30:23] = 8'h01;
            6: v[30:23] = 8'(60 + $urandom_range(0, 10));
            7: v[30:23] = 8'(190 + $urandom_range(0, 10));
            default: ;
        endcase
        return v;
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, cycle %0d expected completion", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        #1;
        do_reset();

        // Single isolated operation: result exactly three edges after sampling
        dop(32'h3FC00000, 32'h40000000, 3'd0, 32'h40400000, 1'b0, 1'b0);
        idle(4, 1'b0);

        // Overflow in each direction-sensitive mode
        dop(32'h7F7FFFFF, 32'h40000000, 3'd0, 32'h7F800000, 1'b1, 1'b0);
        dop(32'h7F7FFFFF, 32'h40000000, 3'd1, 32'h7F7FFFFF, 1'b1, 1'b0);
        dop(32'hFF7FFFFF, 32'h40000000, 3'd3, 32'hFF7FFFFF, 1'b1, 1'b0);
        dop(32'hFF7FFFFF, 32'h40000000, 3'd2, 32'hFF800000, 1'b1, 1'b0);
        dop(32'h7F7FFFFF, 32'h40000000, 3'd4, 32'h7F800000, 1'b1, 1'b0);

        // Underflow to signed zero
        dop(32'h00800000, 32'h00800000, 3'd0, 32'h00000000, 1'b0, 1'b1);
        dop(32'h80800000, 32'h00800000, 3'd0, 32'h80000000, 1'b0, 1'b1);

        // Sticky-only rounding across the modes
        dop(32'h3F800001, 32'h3F800001, 3'd0, 32'h3F800002, 1'b0, 1'b0);
        dop(32'h3F800001, 32'h3F800001, 3'd1, 32'h3F800002, 1'b0, 1'b0);
        dop(32'h3F800001, 32'h3F800001, 3'd3, 32'h3F800003, 1'b0, 1'b0);
        dop(32'h3F800001, 32'h3F800001, 3'd2, 32'h3F800002, 1'b0, 1'b0);

        // Exact tie with an even result: RNE keeps it, RMM rounds away, 101 acts as RNE
        dop(32'h3F800003, 32'h3FC00000, 3'd0, 32'h3FC00004, 1'b0, 1'b0);
        dop(32'h3F800003, 32'h3FC00000, 3'd4, 32'h3FC00005, 1'b0, 1'b0);
        dop(32'h3F800003, 32'h3FC00000, 3'd5, 32'h3FC00004, 1'b0, 1'b0);

        // Special operands
        dop(32'h7F800000, 32'h00000000, 3'd0, 32'h7FC00000, 1'b0, 1'b0);
        dop(32'h7FC00001, 32'h3F800000, 3'd0, 32'h7FC00000, 1'b0, 1'b0);
        dop(32'h00000001, 32'h3F800000, 3'd0, 32'h00000000, 1'b0, 1'b0);
        dop(32'hFF800000, 32'h40000000, 3'd0, 32'hFF800000, 1'b0, 1'b0);
        idle(4, 1'b0);

        // Sticky flags hold through idle cycles, then a clear drops them
        idle(3, 1'b0);
        idle(1, 1'b1);
        idle(2, 1'b0);

        // Reset with operations in flight: the flushed ops never emerge
        for (int i = 0; i < 4; i++) rop(rnd_op(), rnd_op(), 3'($urandom_range(0, 7)), 1'b0);
        do_reset();
        for (int i = 0; i < 2; i++) rop(rnd_op(), rnd_op(), 3'($urandom_range(0, 7)), 1'b0);
        idle(5, 1'b0);

        // Random traffic with bubbles and occasional flag clears
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 4) == 0)
                idle(1, ($urandom_range(0, 7) == 0));
            else
                rop(rnd_op(), rnd_op(), 3'($urandom_range(0, 7)), ($urandom_range(0, 7) == 0));
        end
        idle(6, 1'b0);
        chk("drained", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
